// File: rtl/mem_exc_pkg.sv
// mem_exc_pkg: shared CP0 definitions for the memory-stage exception block.
// Holds CP0 register numbers, exception codes, SR/Cause bit positions and
// a helper that assembles the architectural Cause word from its fields.
// The address checker's validity encodings live with the checker, not here.
package mem_exc_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    // Exception codes as stored in Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5
    } exc_code_e;

    // SR bit positions
    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned SR_IM_LO = 10;
    localparam int unsigned SR_IM_HI = 15;

    // Only IM, EXL and IE exist in SR; every other bit is hardwired to 0.
    localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

    // Cause bit positions
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    // Assemble the Cause word from its stored fields.
    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input exc_code_e code);
        logic [31:0] w;
        w = 32'h0;
        w[CAUSE_BD] = bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO] = code;
        return w;
    endfunction

endpackage

// File: rtl/mem_exc_encoder.sv
// exc_encoder: combinational priority resolution for the MEM stage.
// Priority: interrupt > address fault (AdEL/AdES) > eret. mtc0 is resolved
// by the caller as "neither take nor is_eret".
// Ports:
//   mem_valid, mem_load, mem_store, validity : MEM-stage access and ac verdict
//   sr_ie, sr_exl                            : current SR enable bits
//   int_pending                              : |(hw_int & SR.IM)
//   eret                                     : eret in MEM
//   take                                     : an exception is taken this cycle
//   code                                     : ExcCode of the taken exception
//   is_addr                                  : taken exception is an address fault
//   is_eret                                  : eret proceeds (no exception)
module exc_encoder
    import mem_exc_pkg::*;
(
    input  logic       mem_valid,
    input  logic       mem_load,
    input  logic       mem_store,
    input  logic [2:0] validity,
    input  logic       sr_ie,
    input  logic       sr_exl,
    input  logic       int_pending,
    input  logic       eret,
    output logic       take,
    output exc_code_e  code,
    output logic       is_addr,
    output logic       is_eret
);

    logic int_req;
    logic addr_fault;

    always_comb begin
        int_req    = mem_valid & sr_ie & ~sr_exl & int_pending;
        // Address faults ignore EXL so nested faults are still recorded.
        addr_fault = mem_valid & (mem_load | mem_store) & (validity != 3'b000);

        take    = int_req | addr_fault;
        is_addr = addr_fault & ~int_req;
        is_eret = eret & ~take;

        code = EXC_INT;
        if (is_addr) begin
            code = mem_load ? EXC_ADEL : EXC_ADES;
        end
    end

endmodule

// File: rtl/mem_exc.sv
// mem_exc: memory-stage exception and CP0 block.
// Turns a faulting MEM-stage load/store into AdEL/AdES, takes masked
// hardware interrupts, holds SR/Cause/EPC/BadVAddr/PRId and drives the
// pipeline flush, handler redirect and eret return.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mem_valid/pc/bd/addr       : MEM-stage instruction info
//   mem_load, mem_store        : access type
//   validity                   : address checker verdict, nonzero = fault
//   hw_int                     : level-sensitive interrupt lines
//   cp0_we/sel/wdata           : mtc0 commit; cp0_sel also selects mfc0 read
//   eret                       : eret in MEM
//   cp0_rdata                  : mfc0 data (pre-edge state, no write-through)
//   exc_flush, exc_target      : flush and redirect PC
//   exc_commit_kill            : suppress MEM write and writeback
module mem_exc
    import mem_exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h0000_2019
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic [31:0] mem_addr,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [2:0]  validity,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_sel,
    input  logic [31:0] cp0_wdata,
    input  logic        eret,
    output logic [31:0] cp0_rdata,
    output logic        exc_flush,
    output logic [31:0] exc_target,
    output logic        exc_commit_kill
);

    logic [31:0] sr_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    exc_code_e   code_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;

    logic        take;
    exc_code_e   code;
    logic        is_addr;
    logic        is_eret;
    logic        mtc0;
    logic        int_pending;

    assign int_pending = |(hw_int & sr_q[SR_IM_HI:SR_IM_LO]);

    exc_encoder u_exc_encoder (
        .mem_valid   (mem_valid),
        .mem_load    (mem_load),
        .mem_store   (mem_store),
        .validity    (validity),
        .sr_ie       (sr_q[SR_IE]),
        .sr_exl      (sr_q[SR_EXL]),
        .int_pending (int_pending),
        .eret        (eret),
        .take        (take),
        .code        (code),
        .is_addr     (is_addr),
        .is_eret     (is_eret)
    );

    assign mtc0 = cp0_we & ~take & ~is_eret;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= 32'h0;
            bd_q       <= 1'b0;
            ip_q       <= 6'h0;
            code_q     <= EXC_INT;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
        end else begin
            ip_q <= hw_int;
            if (take) begin
                sr_q[SR_EXL] <= 1'b1;
                code_q       <= code;
                bd_q         <= mem_bd;
                epc_q        <= mem_bd ? (mem_pc - 32'd4) : mem_pc;
                if (is_addr) begin
                    badvaddr_q <= mem_addr;
                end
            end else if (is_eret) begin
                sr_q[SR_EXL] <= 1'b0;
            end else if (mtc0) begin
                if (cp0_sel == CP0_SR) begin
                    sr_q <= cp0_wdata & SR_WMASK;
                end else if (cp0_sel == CP0_EPC) begin
                    epc_q <= cp0_wdata;
                end
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_sel)
            CP0_SR:       cp0_rdata = sr_q;
            CP0_CAUSE:    cp0_rdata = pack_cause(bd_q, ip_q, code_q);
            CP0_EPC:      cp0_rdata = epc_q;
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_PRID:     cp0_rdata = PRID;
            default:      cp0_rdata = 32'h0;
        endcase
    end

    // Outputs are forced quiet while reset is held, even if a fault is present.
    always_comb begin
        exc_flush       = 1'b0;
        exc_target      = 32'h0;
        exc_commit_kill = 1'b0;
        if (!reset) begin
            if (take) begin
                exc_flush       = 1'b1;
                exc_target      = HANDLER_PC;
                exc_commit_kill = 1'b1;
            end else if (is_eret) begin
                exc_flush  = 1'b1;
                exc_target = epc_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_exc.sv
module tb_mem_exc;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [31:0] mem_addr;
    logic        mem_load;
    logic        mem_store;
    logic [2:0]  validity;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        exc_commit_kill;

    mem_exc dut (
        .clk             (clk),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_pc          (mem_pc),
        .mem_bd          (mem_bd),
        .mem_addr        (mem_addr),
        .mem_load        (mem_load),
        .mem_store       (mem_store),
        .validity        (validity),
        .hw_int          (hw_int),
        .cp0_we          (cp0_we),
        .cp0_sel         (cp0_sel),
        .cp0_wdata       (cp0_wdata),
        .eret            (eret),
        .cp0_rdata       (cp0_rdata),
        .exc_flush       (exc_flush),
        .exc_target      (exc_target),
        .exc_commit_kill (exc_commit_kill)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [4:0] R_BADV  = 5'd8;
    localparam logic [4:0] R_SR    = 5'd12;
    localparam logic [4:0] R_CAUSE = 5'd13;
    localparam logic [4:0] R_EPC   = 5'd14;
    localparam logic [4:0] R_PRID  = 5'd15;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    task automatic push_exp(input string tag, input logic [31:0] v);
        sb_entry_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        sb_entry_t e;
        e = sb.pop_front();
        n_assert++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        mem_pc    = 32'h0;
        mem_bd    = 1'b0;
        mem_addr  = 32'h0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        validity  = 3'b000;
        cp0_we    = 1'b0;
        cp0_sel   = 5'd0;
        cp0_wdata = 32'h0;
        eret      = 1'b0;
    endtask

    // One rising edge, then settle; inputs return to idle (hw_int is kept).
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input string tag, input logic [4:0] sel, input logic [31:0] v);
        cp0_sel = sel;
        push_exp(tag, v);
        #1;
        compare(cp0_rdata);
    endtask

    task automatic chk_out(input string tag, input logic flush, input logic [31:0] target,
                           input logic kill);
        push_exp({tag, ".flush"}, {31'h0, flush});
        push_exp({tag, ".kill"}, {31'h0, kill});
        if (flush) push_exp({tag, ".target"}, target);
        #1;
        compare({31'h0, exc_flush});
        compare({31'h0, exc_commit_kill});
        if (flush) compare(exc_target);
    endtask

    task automatic drive_fault(input logic ld, input logic [31:0] pc, input logic bd,
                               input logic [31:0] addr, input logic [2:0] v);
        mem_valid = 1'b1;
        mem_load  = ld;
        mem_store = ~ld;
        mem_pc    = pc;
        mem_bd    = bd;
        mem_addr  = addr;
        validity  = v;
    endtask

    initial begin
        idle();
        hw_int = 6'h0;
        reset  = 1'b1;

        // Reset held with a fault present: outputs quiet, no state change.
        drive_fault(1'b1, 32'h0000_3010, 1'b0, 32'h0000_3000, 3'b001);
        chk_out("reset_fault", 1'b0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        rd("rst_sr", R_SR, 32'h0);
        rd("rst_cause", R_CAUSE, 32'h0);
        rd("rst_epc", R_EPC, 32'h0);
        rd("rst_badv", R_BADV, 32'h0);
        rd("rst_prid", R_PRID, 32'h0000_2019);

        // Load fault
        drive_fault(1'b1, 32'h0000_3010, 1'b0, 32'h0000_3000, 3'b001);
        chk_out("adel", 1'b1, HANDLER, 1'b1);
        step();
        rd("adel_sr", R_SR, 32'h0000_0002);
        rd("adel_cause", R_CAUSE, 32'h0000_0010);
        rd("adel_epc", R_EPC, 32'h0000_3010);
        rd("adel_badv", R_BADV, 32'h0000_3000);

        // Store fault in a delay slot, nested under EXL=1
        drive_fault(1'b0, 32'h0000_3020, 1'b1, 32'h0000_0001, 3'b010);
        chk_out("ades", 1'b1, HANDLER, 1'b1);
        step();
        rd("ades_cause", R_CAUSE, 32'h8000_0014);
        rd("ades_epc", R_EPC, 32'h0000_301C);
        rd("ades_badv", R_BADV, 32'h0000_0001);

        // mtc0 EPC, then eret
        cp0_we = 1'b1; cp0_sel = R_EPC; cp0_wdata = 32'h0000_3010;
        chk_out("mtc0_epc", 1'b0, 32'h0, 1'b0);
        step();
        rd("mtc0_epc_rd", R_EPC, 32'h0000_3010);
        mem_valid = 1'b1; eret = 1'b1;
        chk_out("eret", 1'b1, 32'h0000_3010, 1'b0);
        step();
        rd("eret_sr", R_SR, 32'h0);

        // Interrupt beats a simultaneous load fault
        cp0_we = 1'b1; cp0_sel = R_SR; cp0_wdata = 32'hFFFF_0401;
        step();
        rd("mtc0_sr", R_SR, 32'h0000_0401);
        hw_int = 6'b000001;
        drive_fault(1'b1, 32'h0000_3040, 1'b0, 32'h0000_5000, 3'b001);
        chk_out("int", 1'b1, HANDLER, 1'b1);
        step();
        rd("int_cause", R_CAUSE, 32'h0000_0400);
        rd("int_badv", R_BADV, 32'h0000_0001);
        rd("int_epc", R_EPC, 32'h0000_3040);
        rd("int_sr", R_SR, 32'h0000_0403);

        // eret + fault + mtc0 together: only the fault is taken
        hw_int = 6'h0;
        drive_fault(1'b1, 32'h0000_3050, 1'b0, 32'h0000_6000, 3'b100);
        eret = 1'b1; cp0_we = 1'b1; cp0_sel = R_EPC; cp0_wdata = 32'hDEAD_BEEF;
        chk_out("eret_fault", 1'b1, HANDLER, 1'b1);
        step();
        rd("ef_epc", R_EPC, 32'h0000_3050);
        rd("ef_sr", R_SR, 32'h0000_0403);
        rd("ef_cause", R_CAUSE, 32'h0000_0010);
        rd("ef_badv", R_BADV, 32'h0000_6000);

        // Clear EXL, then a bubble with hw_int active: no exception
        mem_valid = 1'b1; eret = 1'b1;
        step();
        rd("clr_sr", R_SR, 32'h0000_0401);
        hw_int = 6'b000001;
        chk_out("bubble", 1'b0, 32'h0, 1'b0);
        step();
        rd("bubble_sr", R_SR, 32'h0000_0401);
        // Next valid instruction takes the interrupt
        mem_valid = 1'b1; mem_pc = 32'h0000_3060;
        chk_out("int_late", 1'b1, HANDLER, 1'b1);
        step();
        rd("int_late_epc", R_EPC, 32'h0000_3060);

        // Nonzero validity without load/store is ignored
        hw_int = 6'h0;
        mem_valid = 1'b1; eret = 1'b1;
        step();
        mem_valid = 1'b1; validity = 3'b001; mem_pc = 32'h0000_3070;
        chk_out("no_access", 1'b0, 32'h0, 1'b0);
        step();
        // Writes to Cause are ignored
        cp0_we = 1'b1; cp0_sel = R_CAUSE; cp0_wdata = 32'hFFFF_FFFF;
        step();
        rd("cause_ro", R_CAUSE, 32'h0);

        // EPC wrap in a delay slot at PC 0, then reset mid-handler
        drive_fault(1'b0, 32'h0000_0000, 1'b1, 32'h0000_0002, 3'b001);
        chk_out("wrap", 1'b1, HANDLER, 1'b1);
        step();
        rd("wrap_epc", R_EPC, 32'hFFFF_FFFC);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd("r2_sr", R_SR, 32'h0);
        rd("r2_cause", R_CAUSE, 32'h0);
        rd("r2_epc", R_EPC, 32'h0);
        rd("r2_badv", R_BADV, 32'h0);
        rd("r2_prid", R_PRID, 32'h0000_2019);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
